// File: rtl/vpu_dcache_arbiter.sv
// Arbitrates the single D$ request port between the scalar CPU LSU and the VPU LSU.
// Optional stall counters are enabled with `define VPU_DCACHE_ARB_PERF_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner, D$ request low, arbitrating for next cycle
// OWN_CPU | CPU LSU owns the D$ port
// OWN_VPU | VPU LSU owns the D$ port (may be locked for vector bursts)
module vpu_dcache_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int MAX_LOCK_BEATS = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cpu_req_i,
  input  logic [3:0]    cpu_write_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_in_i,
  output logic          cpu_wait_o,
  output logic [DW-1:0] cpu_out_o,
  input  logic          vpu_req_i,
  input  logic [3:0]    vpu_write_i,
  input  logic [AW-1:0] vpu_addr_i,
  input  logic [DW-1:0] vpu_in_i,
  input  logic          vpu_lock_i,
  output logic          vpu_wait_o,
  output logic [DW-1:0] vpu_out_o,
  output logic          dc_req_o,
  output logic [3:0]    dc_write_o,
  output logic [AW-1:0] dc_addr_o,
  output logic [DW-1:0] dc_in_o,
  input  logic          dc_wait_i,
  input  logic [DW-1:0] dc_out_i
`ifdef VPU_DCACHE_ARB_PERF_EN
  ,
  output logic [31:0]   cpu_stall_cnt_o,
  output logic [31:0]   vpu_stall_cnt_o
`endif
);

  localparam int LCW = $clog2(MAX_LOCK_BEATS + 1);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(MAX_LOCK_BEATS - 1);

  typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_VPU} state_t;

  state_t         state;
  logic           last_vpu;
  logic [LCW-1:0] lock_cnt;

  logic own_cpu, own_vpu, done_cpu, done_vpu, lock_hit;

  // Both pending: the requester not served last wins.
  function automatic state_t arb(input logic c, input logic v, input logic last_v);
    if (c && v)  return last_v ? OWN_CPU : OWN_VPU;
    else if (c)  return OWN_CPU;
    else if (v)  return OWN_VPU;
    else         return IDLE;
  endfunction

  assign own_cpu  = (state == OWN_CPU);
  assign own_vpu  = (state == OWN_VPU);
  assign done_cpu = own_cpu & cpu_req_i & ~dc_wait_i;
  assign done_vpu = own_vpu & vpu_req_i & ~dc_wait_i;
  assign lock_hit = (lock_cnt >= LOCK_LAST);

  assign cpu_wait_o = cpu_req_i & ~done_cpu;
  assign vpu_wait_o = vpu_req_i & ~done_vpu;
  assign cpu_out_o  = dc_out_i;
  assign vpu_out_o  = dc_out_i;
  assign dc_req_o   = (own_cpu & cpu_req_i) | (own_vpu & vpu_req_i);

  always_comb begin
    dc_write_o = '0;
    dc_addr_o  = '0;
    dc_in_o    = '0;
    if (own_cpu) begin
      dc_write_o = cpu_write_i;
      dc_addr_o  = cpu_addr_i;
      dc_in_o    = cpu_in_i;
    end else if (own_vpu) begin
      dc_write_o = vpu_write_i;
      dc_addr_o  = vpu_addr_i;
      dc_in_o    = vpu_in_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      last_vpu <= 1'b1;
      lock_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          lock_cnt <= '0;
          state    <= arb(cpu_req_i, vpu_req_i, last_vpu);
        end
        OWN_CPU: begin
          lock_cnt <= '0;
          if (done_cpu) begin
            last_vpu <= 1'b0;
            state    <= arb(cpu_req_i, vpu_req_i, 1'b0);
          end else if (!cpu_req_i) begin
            state <= arb(1'b0, vpu_req_i, last_vpu);
          end
        end
        OWN_VPU: begin
          if (done_vpu) begin
            last_vpu <= 1'b1;
            if (vpu_lock_i) begin
              // Counter saturates so a late CPU request still breaks the lock.
              if (cpu_req_i && lock_hit) begin
                state    <= OWN_CPU;
                lock_cnt <= '0;
              end else if (!lock_hit) begin
                lock_cnt <= lock_cnt + 1'b1;
              end
            end else begin
              state <= arb(cpu_req_i, vpu_req_i, 1'b1);
              if (cpu_req_i) lock_cnt <= '0;
            end
          end else if (!vpu_req_i) begin
            state    <= arb(cpu_req_i, 1'b0, last_vpu);
            lock_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VPU_DCACHE_ARB_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cpu_stall_cnt_o <= '0;
      vpu_stall_cnt_o <= '0;
    end else begin
      if (cpu_req_i && cpu_wait_o && (cpu_stall_cnt_o != '1))
        cpu_stall_cnt_o <= cpu_stall_cnt_o + 32'd1;
      if (vpu_req_i && vpu_wait_o && (vpu_stall_cnt_o != '1))
        vpu_stall_cnt_o <= vpu_stall_cnt_o + 32'd1;
    end
  end
`else
  // Stall counters are not built; arbitration is unaffected.
`endif

endmodule

// File: tb/tb_vpu_dcache_arbiter.sv
// Directed self-checking bench for vpu_dcache_arbiter (built with MAX_LOCK_BEATS=4).
module tb_vpu_dcache_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cpu_req_i, vpu_req_i, vpu_lock_i, dc_wait_i;
  logic [3:0]    cpu_write_i, vpu_write_i;
  logic [AW-1:0] cpu_addr_i, vpu_addr_i;
  logic [DW-1:0] cpu_in_i, vpu_in_i, dc_out_i;
  logic          cpu_wait_o, vpu_wait_o, dc_req_o;
  logic [DW-1:0] cpu_out_o, vpu_out_o, dc_in_o;
  logic [3:0]    dc_write_o;
  logic [AW-1:0] dc_addr_o;
`ifdef VPU_DCACHE_ARB_PERF_EN
  logic [31:0]   cpu_stall_cnt_o, vpu_stall_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  vpu_dcache_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK_BEATS(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i), .cpu_addr_i(cpu_addr_i),
    .cpu_in_i(cpu_in_i), .cpu_wait_o(cpu_wait_o), .cpu_out_o(cpu_out_o),
    .vpu_req_i(vpu_req_i), .vpu_write_i(vpu_write_i), .vpu_addr_i(vpu_addr_i),
    .vpu_in_i(vpu_in_i), .vpu_lock_i(vpu_lock_i), .vpu_wait_o(vpu_wait_o),
    .vpu_out_o(vpu_out_o),
    .dc_req_o(dc_req_o), .dc_write_o(dc_write_o), .dc_addr_o(dc_addr_o),
    .dc_in_o(dc_in_o), .dc_wait_i(dc_wait_i), .dc_out_i(dc_out_i)
`ifdef VPU_DCACHE_ARB_PERF_EN
    , .cpu_stall_cnt_o(cpu_stall_cnt_o), .vpu_stall_cnt_o(vpu_stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req_i = 0; cpu_write_i = 0; cpu_addr_i = 0; cpu_in_i = 0;
    vpu_req_i = 0; vpu_write_i = 0; vpu_addr_i = 0; vpu_in_i = 0;
    vpu_lock_i = 0; dc_wait_i = 0; dc_out_i = 0;
  endtask

  task automatic do_reset();
    rst_i = 1;
    idle_inputs();
    cyc();
    cyc();
    rst_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int vb;
    logic cpu_pend;

    // Reset state, with both requests raised to see the combinational waits.
    rst_i = 1;
    idle_inputs();
    cpu_req_i = 1; vpu_req_i = 1;
    cyc(); cyc(); settle();
    expect_eq("rst_dc_req",   dc_req_o,   0);
    expect_eq("rst_dc_addr",  dc_addr_o,  0);
    expect_eq("rst_dc_write", dc_write_o, 0);
    expect_eq("rst_dc_in",    dc_in_o,    0);
    expect_eq("rst_cpu_wait", cpu_wait_o, 1);
    expect_eq("rst_vpu_wait", vpu_wait_o, 1);
    cpu_req_i = 0; vpu_req_i = 0; rst_i = 0;
    settle();
    expect_eq("rst_cpu_wait_lo", cpu_wait_o, 0);
    cyc();

    // CPU-only read at 0x100.
    cpu_req_i = 1; cpu_addr_i = 32'h100; dc_out_i = 32'hDEADBEEF;
    settle();
    expect_eq("t1_idle_req",  dc_req_o,   0);
    expect_eq("t1_idle_wait", cpu_wait_o, 1);
    cyc(); settle();
    expect_eq("t1_dc_req",   dc_req_o,   1);
    expect_eq("t1_dc_addr",  dc_addr_o,  32'h100);
    expect_eq("t1_dc_write", dc_write_o, 0);
    expect_eq("t1_cpu_wait", cpu_wait_o, 0);
    expect_eq("t1_cpu_out",  cpu_out_o,  32'hDEADBEEF);
    expect_eq("t1_vpu_wait", vpu_wait_o, 0);
    cpu_req_i = 0;
    settle();
    expect_eq("t1_drop_req", dc_req_o, 0);
    cyc();

    // Simultaneous requests after reset: CPU first, then VPU with no bubble.
    do_reset();
    cpu_req_i = 1; cpu_addr_i = 32'h300; cpu_write_i = 4'h0;
    vpu_req_i = 1; vpu_addr_i = 32'h400; vpu_write_i = 4'hF; vpu_in_i = 32'h55;
    dc_out_i = 32'h1234_5678;
    settle();
    expect_eq("t2_idle_cpu_wait", cpu_wait_o, 1);
    expect_eq("t2_idle_vpu_wait", vpu_wait_o, 1);
    cyc(); settle();
    expect_eq("t2_cpu_addr",  dc_addr_o,  32'h300);
    expect_eq("t2_cpu_wait",  cpu_wait_o, 0);
    expect_eq("t2_vpu_hold",  vpu_wait_o, 1);
    expect_eq("t2_cpu_req",   dc_req_o,   1);
    cyc();
    cpu_req_i = 0; dc_out_i = 32'hCAFE_F00D;
    settle();
    expect_eq("t2_vpu_req",   dc_req_o,   1);
    expect_eq("t2_vpu_addr",  dc_addr_o,  32'h400);
    expect_eq("t2_vpu_write", dc_write_o, 4'hF);
    expect_eq("t2_vpu_in",    dc_in_o,    32'h55);
    expect_eq("t2_vpu_wait",  vpu_wait_o, 0);
    expect_eq("t2_vpu_out",   vpu_out_o,  32'hCAFE_F00D);
    cyc();
    vpu_req_i = 0;
    settle();
    expect_eq("t2_drop_req", dc_req_o, 0);
    cyc();
`ifdef VPU_DCACHE_ARB_PERF_EN
    expect_eq("t2_cpu_stall_cnt", cpu_stall_cnt_o, 1);
    expect_eq("t2_vpu_stall_cnt", vpu_stall_cnt_o, 2);
`endif

    // Locked 8-beat vse, two cycles per beat, CPU idle.
    vpu_req_i = 1; vpu_lock_i = 1; vpu_write_i = 4'hF; vpu_addr_i = 32'h200;
    cyc();
    for (int i = 0; i < 8; i++) begin
      vpu_addr_i = 32'h200 + 32'(4 * i); vpu_in_i = 32'(i); dc_wait_i = 1;
      settle();
      expect_eq($sformatf("t3_req_b%0d", i),  dc_req_o,   1);
      expect_eq($sformatf("t3_hold_b%0d", i), vpu_wait_o, 1);
      cyc();
      dc_wait_i = 0;
      settle();
      expect_eq($sformatf("t3_addr_b%0d", i),  dc_addr_o,  32'h200 + 32'(4 * i));
      expect_eq($sformatf("t3_write_b%0d", i), dc_write_o, 4'hF);
      expect_eq($sformatf("t3_done_b%0d", i),  vpu_wait_o, 0);
      cyc();
    end
    vpu_req_i = 0; vpu_lock_i = 0;
    settle();
    expect_eq("t3_end_req", dc_req_o, 0);
    cyc();

    // Lock bound of 4: CPU arrives at VPU beat 1, is granted after beat 4.
    vb = 0; cpu_pend = 1;
    vpu_req_i = 1; vpu_lock_i = 1; vpu_write_i = 4'hF; vpu_addr_i = 32'h500;
    cyc();
    cpu_addr_i = 32'h600; cpu_write_i = 4'h0;
    for (int k = 0; k < 11; k++) begin
      vpu_addr_i = 32'h500 + 32'(4 * vb);
      cpu_req_i = cpu_pend;
      settle();
      if (k == 4) begin
        expect_eq("t4_cpu_addr",  dc_addr_o,  32'h600);
        expect_eq("t4_cpu_write", dc_write_o, 4'h0);
        expect_eq("t4_cpu_wait",  cpu_wait_o, 0);
        expect_eq("t4_vpu_hold",  vpu_wait_o, 1);
      end else begin
        expect_eq($sformatf("t4_vaddr_k%0d", k), dc_addr_o, 32'h500 + 32'(4 * vb));
        expect_eq($sformatf("t4_vwait_k%0d", k), vpu_wait_o, 0);
        expect_eq($sformatf("t4_cwait_k%0d", k), cpu_wait_o, cpu_pend);
      end
      cyc();
      if (k == 4) cpu_pend = 0;
      else        vb++;
    end
    vpu_req_i = 0; vpu_lock_i = 0; cpu_req_i = 0;
    settle();
    expect_eq("t4_end_req", dc_req_o, 0);
    cyc();

    // VPU abandons its beat while CPU is pending.
    vpu_req_i = 1; vpu_addr_i = 32'h800;
    cyc();
    cpu_req_i = 1; cpu_addr_i = 32'h700; dc_wait_i = 1;
    settle();
    expect_eq("t5_vpu_req",  dc_req_o,   1);
    expect_eq("t5_cpu_hold", cpu_wait_o, 1);
    cyc();
    vpu_req_i = 0;
    settle();
    expect_eq("t5_abort_req",  dc_req_o,   0);
    expect_eq("t5_abort_vwait", vpu_wait_o, 0);
    cyc(); settle();
    expect_eq("t5_cpu_req",  dc_req_o,   1);
    expect_eq("t5_cpu_addr", dc_addr_o,  32'h700);
    expect_eq("t5_cpu_busy", cpu_wait_o, 1);
    dc_wait_i = 0;
    settle();
    expect_eq("t5_cpu_done", cpu_wait_o, 0);
    cyc();
    cpu_req_i = 0;
    cyc();

    // Reset pulsed mid-beat while VPU owns the port.
    vpu_req_i = 1; vpu_addr_i = 32'h900; dc_wait_i = 1;
    cyc(); settle();
    expect_eq("t6_pre_req", dc_req_o, 1);
    rst_i = 1;
    cyc();
    rst_i = 0;
    settle();
    expect_eq("t6_rst_req",  dc_req_o,   0);
    expect_eq("t6_rst_addr", dc_addr_o,  0);
    expect_eq("t6_rst_vwait", vpu_wait_o, 1);
`ifdef VPU_DCACHE_ARB_PERF_EN
    expect_eq("t6_cpu_stall_cnt", cpu_stall_cnt_o, 0);
    expect_eq("t6_vpu_stall_cnt", vpu_stall_cnt_o, 0);
`endif
    vpu_req_i = 0; dc_wait_i = 0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vpu_dcache_arbiter.md
Name: vpu_dcache_arbiter

Overview:
- Shares the single D$ request port between the scalar CPU LSU and the VPU execute-stage LSU.
- Registered grant FSM; round-robin between requesters, with a VPU lock for back-to-back vector element accesses.
- Bounded lock length so scalar loads/stores cannot starve behind long vle/vse sequences.
- Sits between the CPU/VPU top level and the D$; VPU connects via its dcache_vpu_* ports.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_LOCK_BEATS, 16, max consecutive locked VPU beats while CPU is pending (≥1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cpu_req_i  in  1  CPU access request, held until completion
- cpu_write_i  in  4  CPU byte write enables (0 = read)
- cpu_addr_i  in  AW  CPU address
- cpu_in_i  in  DW  CPU write data
- cpu_wait_o  out  1  CPU stall; low with cpu_req_i high = beat done
- cpu_out_o  out  DW  read data to CPU
- vpu_req_i  in  1  VPU request (dcache_vpu_request_o)
- vpu_write_i  in  4  VPU byte write enables
- vpu_addr_i  in  AW  VPU address
- vpu_in_i  in  DW  VPU write data
- vpu_lock_i  in  1  VPU asks to keep grant after current beat
- vpu_wait_o  out  1  VPU stall (to dcache_vpu_wait_i)
- vpu_out_o  out  DW  read data to VPU
- dc_req_o  out  1  request to D$
- dc_write_o  out  4  byte write enables to D$
- dc_addr_o  out  AW  address to D$
- dc_in_o  out  DW  write data to D$
- dc_wait_i  in  1  D$ busy; low = current beat accepted/complete
- dc_out_i  in  DW  D$ read data

Behaviour:
- Clock and reset: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset: state IDLE, last_served=VPU (CPU wins first tie), lock_cnt=0.
  - dc_req_o=0, dc_write_o=0, dc_addr_o=0, dc_in_o=0.
  - cpu_wait_o=cpu_req_i, vpu_wait_o=vpu_req_i (combinational).
- States: IDLE, OWN_CPU, OWN_VPU.
- IDLE: dc_req_o=0; next state by arbitration (below); 1-cycle grant latency.
- OWN_x: dc_req_o=x_req_i; dc_write/addr/in muxed from owner; non-owner fields ignored.
- Beat complete (done_x) = state OWN_x & x_req_i & ~dc_wait_i.
- x_wait_o = x_req_i & ~done_x.
- cpu_out_o = vpu_out_o = dc_out_i (broadcast); valid only on the requester's done cycle.
- Arbitration (from IDLE, or on done / owner drop):
  - Only one requester pending → grant it.
  - Both pending → grant the one not equal to last_served.
  - Neither pending → IDLE.
- On done_x: last_served=x; next state by arbitration, considering x's req as still pending if x_req_i remains high. Back-to-back beats have no bubble.
- VPU lock: on done_VPU with vpu_lock_i=1 and vpu_req_i=1, stay in OWN_VPU and lock_cnt++.
  - If cpu_req_i=1 and lock_cnt+1 == MAX_LOCK_BEATS: go to OWN_CPU, lock_cnt=0.
  - lock_cnt clears on any CPU grant or on entering IDLE.
- Owner drops req in OWN_x without done (abort): dc_req_o=0 that cycle; next state by arbitration. No D$ transaction is started.
- Non-owner requests are held with wait=1; fields must stay stable until its done.
- Reset mid-beat: returns to IDLE immediately. The requester re-issues after reset.
- Invariants:
  - Never two done signals in one cycle.
  - dc_req_o only in OWN_* states.
  - vpu_lock_i is ignored in OWN_CPU and IDLE.

Optional Feature:
- Macro: VPU_DCACHE_ARB_PERF_EN.
- Defined: adds outputs cpu_stall_cnt_o[31:0] and vpu_stall_cnt_o[31:0].
  - Each increments every cycle x_req_i & x_wait_o; saturates at 2^32-1; reset to 0.
- Undefined: ports and counters absent; arbitration behaviour identical.

Test Plan:
- CPU-only read, addr 0x100, dc_wait_i low → dc_req_o at cycle+1, cpu_wait_o low that cycle, cpu_out_o=dc_out_i=0xDEADBEEF; vpu_wait_o=0.
- Both req in same cycle after reset → CPU served first, then VPU with no idle cycle; vpu_wait_o high until its done.
- VPU vse 8 beats, lock=1, dc_wait_i held 2 cycles per beat, CPU idle → 8 consecutive OWN_VPU beats, addrs 0x200..0x21C, dc_write_o=0xF each.
- MAX_LOCK_BEATS=4, VPU locked stream of 10 beats, CPU req asserted at VPU beat 1 → CPU granted after 4th locked VPU beat, then VPU resumes; no beat lost.
- VPU drops req while owner with dc_wait_i=1 → dc_req_o=0 same cycle, pending CPU granted next cycle.
- rst_i pulsed mid-beat in OWN_VPU → next cycle IDLE, dc_req_o=0; with VPU_DCACHE_ARB_PERF_EN, counters read 0.
